// File: rtl/spi_shift_engine_if.sv
// Handshake and serial-bus bundle for spi_shift_engine.
// Latency: none (wires only). Backpressure: load_ready gates loads, rx_ack drains rx.
// Optional macro SPI_SHIFT_OVERRUN_EN adds the sticky overrun flag.
// Signals: load_valid/load_ready/load_data/lsb_first (load handshake),
//   shift_en/ser_in/ser_out (bit strobe and serial lines), busy,
//   rx_valid/rx_data/rx_ack (receive handshake), overrun (optional).
// Modports: master = the agent that drives loads and strobes;
//   slave = the shift engine itself.
interface spi_shift_engine_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             lsb_first;
  logic             shift_en;
  logic             ser_in;
  logic             ser_out;
  logic             busy;
  logic             rx_valid;
  logic [WIDTH-1:0] rx_data;
  logic             rx_ack;
`ifdef SPI_SHIFT_OVERRUN_EN
  logic             overrun;
`endif

  modport master (
    output load_valid, load_data, lsb_first, shift_en, ser_in, rx_ack,
    input  load_ready, ser_out, busy, rx_valid, rx_data
`ifdef SPI_SHIFT_OVERRUN_EN
    , input overrun
`endif
  );

  modport slave (
    input  load_valid, load_data, lsb_first, shift_en, ser_in, rx_ack,
    output load_ready, ser_out, busy, rx_valid, rx_data
`ifdef SPI_SHIFT_OVERRUN_EN
    , output overrun
`endif
  );
endinterface

// File: rtl/spi_shift_engine.sv
// Bidirectional SPI shift engine: loads a word, shifts one bit per shift_en strobe.
// Latency: rx_valid rises the cycle after the WIDTH-th strobe; one IDLE cycle before the next load.
// Backpressure: load_ready low while shifting; rx_valid held until rx_ack (overrun if unacked, optional).
// Ports: clk, reset (async active-low), bus (spi_shift_engine_if.slave).
// Optional macro SPI_SHIFT_OVERRUN_EN: sticky overrun flag; an unacked completion
// keeps the old rx_data instead of overwriting it.
module spi_shift_engine #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  spi_shift_engine_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic               dir_q, dir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
`ifdef SPI_SHIFT_OVERRUN_EN
  logic               overrun_q, overrun_d;
`endif

  logic [WIDTH-1:0]   shifted;
  logic               done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      dir_q      <= 1'b0;
      cnt_q      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
`ifdef SPI_SHIFT_OVERRUN_EN
      overrun_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      dir_q      <= dir_d;
      cnt_q      <= cnt_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
`ifdef SPI_SHIFT_OVERRUN_EN
      overrun_q  <= overrun_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    dir_d      = dir_q;
    cnt_d      = cnt_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
`ifdef SPI_SHIFT_OVERRUN_EN
    overrun_d  = overrun_q;
`endif
    done       = 1'b0;
    // dir=1 moves bits toward index 0 (LSB out first), dir=0 toward the MSB.
    shifted    = dir_q ? {bus.ser_in, shreg_q[WIDTH-1:1]}
                       : {shreg_q[WIDTH-2:0], bus.ser_in};

    unique case (state_q)
      IDLE: begin
        if (bus.load_valid) begin
          shreg_d = bus.load_data;
          dir_d   = bus.lsb_first;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.shift_en) begin
          shreg_d = shifted;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            cnt_d   = '0;
            state_d = IDLE;
            done    = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Ack is applied first so a completion in the same cycle wins and
    // leaves rx_valid set with the new word.
    if (bus.rx_ack && rx_valid_q) begin
      rx_valid_d = 1'b0;
`ifdef SPI_SHIFT_OVERRUN_EN
      overrun_d  = 1'b0;
`endif
    end

    if (done) begin
`ifdef SPI_SHIFT_OVERRUN_EN
      if (rx_valid_q && !bus.rx_ack) begin
        overrun_d = 1'b1;
      end else begin
        rx_data_d  = shifted;
        rx_valid_d = 1'b1;
      end
`else
      rx_data_d  = shifted;
      rx_valid_d = 1'b1;
`endif
    end
  end

  assign bus.load_ready = (state_q == IDLE);
  assign bus.busy       = (state_q == SHIFT);
  assign bus.ser_out    = dir_q ? shreg_q[0] : shreg_q[WIDTH-1];
  assign bus.rx_valid   = rx_valid_q;
  assign bus.rx_data    = rx_data_q;
`ifdef SPI_SHIFT_OVERRUN_EN
  assign bus.overrun    = overrun_q;
`endif
endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine (WIDTH=8), scoreboard of expected rx words.
// Latency: checks rx_valid the cycle after the last strobe.
// Backpressure: exercises unacked completions, ack-on-completion and reset aborts.
module tb_spi_shift_engine;
  localparam int W = 8;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_rx;
  bit           model_vld;
  bit           model_ovr;

  spi_shift_engine_if #(.WIDTH(W)) bus ();

  spi_shift_engine #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SPI_SHIFT_OVERRUN_EN
  localparam bit OVR = 1'b1;
`else
  localparam bit OVR = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ovr(input string tag);
`ifdef SPI_SHIFT_OVERRUN_EN
    check(tag, {31'd0, bus.overrun}, {31'd0, model_ovr});
`else
    check(tag, {31'd0, bus.rx_valid}, {31'd0, model_vld});
`endif
  endtask

  // One full transfer: load `data`, shift in `rxw` in the same bit order.
  task automatic do_word(input logic [W-1:0] data, input bit lsb, input logic [W-1:0] rxw,
                         input int gapmax, input bit ack_last);
    logic [W-1:0] popped;
    int bi;
    check("load_ready_idle", {31'd0, bus.load_ready}, 32'd1);
    bus.load_valid = 1'b1;
    bus.load_data  = data;
    bus.lsb_first  = lsb;
    tick();
    bus.load_valid = 1'b0;
    // Completion model, evaluated up front and queued for the end of the word.
    if (ack_last) begin
      model_rx = rxw; model_vld = 1'b1; model_ovr = 1'b0;
    end else if (OVR && model_vld) begin
      model_ovr = 1'b1;
    end else begin
      model_rx = rxw; model_vld = 1'b1;
    end
    exp_q.push_back(model_rx);
    for (int i = 0; i < W; i++) begin
      bi = lsb ? i : (W - 1 - i);
      check($sformatf("ser_out_bit%0d", i), {31'd0, bus.ser_out}, {31'd0, data[bi]});
      check("busy_shift", {31'd0, bus.busy}, 32'd1);
      bus.ser_in   = rxw[bi];
      bus.shift_en = 1'b1;
      bus.rx_ack   = ack_last && (i == W - 1);
      tick();
      bus.shift_en = 1'b0;
      bus.rx_ack   = 1'b0;
      if (gapmax > 0 && i < W - 1) begin
        int gap;
        gap = 2 + $urandom_range(0, gapmax);
        for (int g = 0; g < gap; g++) begin
          bus.load_valid = (g == 0);
          bus.load_data  = 8'hFF;
          bus.lsb_first  = ~lsb;
          tick();
          bus.load_valid = 1'b0;
          check("busy_gap", {31'd0, bus.busy}, 32'd1);
        end
      end
    end
    popped = exp_q.pop_front();
    check("rx_valid_done", {31'd0, bus.rx_valid}, 32'd1);
    check("rx_data_done", {24'd0, bus.rx_data}, {24'd0, popped});
    check("busy_done", {31'd0, bus.busy}, 32'd0);
    check_ovr("overrun_done");
  endtask

  task automatic do_ack();
    bus.rx_ack = 1'b1;
    tick();
    bus.rx_ack = 1'b0;
    model_vld = 1'b0;
    model_ovr = 1'b0;
    check("rx_valid_ack", {31'd0, bus.rx_valid}, 32'd0);
    check_ovr("overrun_ack");
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_load_ready"}, {31'd0, bus.load_ready}, 32'd1);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_ser_out"}, {31'd0, bus.ser_out}, 32'd0);
    check({tag, "_rx_valid"}, {31'd0, bus.rx_valid}, 32'd0);
    check({tag, "_rx_data"}, {24'd0, bus.rx_data}, 32'd0);
    check_ovr({tag, "_overrun"});
  endtask

  initial begin
    checks = 0; failures = 0;
    model_rx = '0; model_vld = 1'b0; model_ovr = 1'b0;
    bus.load_valid = 1'b0; bus.load_data = '0; bus.lsb_first = 1'b0;
    bus.shift_en = 1'b0; bus.ser_in = 1'b0; bus.rx_ack = 1'b0;
    reset = 1'b0;
    #2;
    check_reset_vals("reset");
    tick(); tick();
    reset = 1'b1;
    tick();

    // Strobes in IDLE and stray acks must do nothing.
    bus.shift_en = 1'b1; bus.rx_ack = 1'b1;
    tick();
    bus.shift_en = 1'b0; bus.rx_ack = 1'b0;
    check_reset_vals("idle_noop");

    // MSB-first 0xA5 out, 0x3C in.
    do_word(8'hA5, 1'b0, 8'h3C, 0, 1'b0);
    do_ack();
    // LSB-first 0x01 out, 0x80 in.
    do_word(8'h01, 1'b1, 8'h80, 0, 1'b0);
    do_ack();
    // Gapped strobes with ignored load pulses.
    do_word(8'hA5, 1'b0, 8'h3C, 3, 1'b0);
    do_ack();

    // Reset mid-word after four strobes.
    bus.load_valid = 1'b1; bus.load_data = 8'hC3; bus.lsb_first = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.ser_in = 1'b1; bus.shift_en = 1'b1;
      tick();
      bus.shift_en = 1'b0;
    end
    #2;
    reset = 1'b0;
    #1;
    model_vld = 1'b0; model_ovr = 1'b0; model_rx = '0;
    check_reset_vals("abort");
    tick();
    reset = 1'b1;
    tick(); tick();
    check("abort_no_rx", {31'd0, bus.rx_valid}, 32'd0);
    do_word(8'h5A, 1'b0, 8'hE7, 0, 1'b0);
    do_ack();

    // Back-to-back words without ack: overrun keeps 0x11, otherwise 0x22 lands.
    do_word(8'h00, 1'b0, 8'h11, 0, 1'b0);
    do_word(8'h00, 1'b1, 8'h22, 0, 1'b0);
    do_ack();

    // Ack coinciding with completion of a second word.
    do_word(8'h96, 1'b0, 8'h33, 0, 1'b0);
    do_word(8'h69, 1'b1, 8'h44, 1, 1'b1);
    do_ack();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_shift_engine.md
SPI_SHIFT_ENGINE -- requirements
Module: spi_shift_engine

Interface
REQ-001 Parameter: WIDTH, default 8, shift word length in bits; legal range 2..32.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: load_valid  input  1  request to load a new transmit word.
REQ-005 Port: load_ready  output  1  engine can accept a load this cycle.
REQ-006 Port: load_data  input  WIDTH  parallel transmit word.
REQ-007 Port: lsb_first  input  1  bit order for the word being loaded: 1 = LSB first, 0 = MSB first.
REQ-008 Port: shift_en  input  1  single-cycle bit strobe that advances the shift by one bit.
REQ-009 Port: ser_in  input  1  serial receive bit.
REQ-010 Port: ser_out  output  1  serial transmit bit.
REQ-011 Port: busy  output  1  high while a word is in flight.
REQ-012 Port: rx_valid  output  1  received word available.
REQ-013 Port: rx_data  output  WIDTH  received parallel word.
REQ-014 Port: rx_ack  input  1  consumer accepts rx_data; clears rx_valid.
REQ-015 Port: overrun  output  1  sticky overrun flag; present only with SPI_SHIFT_OVERRUN_EN.

Function
REQ-016 FSM has two states: IDLE and SHIFT.
REQ-017 IDLE: load_ready=1 and busy=0; on load_valid=1, shreg<=load_data, dir<=lsb_first, bit counter<=0, next state SHIFT.
REQ-018 SHIFT: load_ready=0 and busy=1; load_valid is ignored.
REQ-019 In SHIFT, with shift_en=1 and dir=1: shreg<={ser_in, shreg[WIDTH-1:1]}.
REQ-020 In SHIFT, with shift_en=1 and dir=0: shreg<={shreg[WIDTH-2:0], ser_in}.
REQ-021 ser_out is combinational: shreg[0] when dir=1, shreg[WIDTH-1] when dir=0, in all states.
REQ-022 shift_en=0 holds shreg and the counter; strobe gaps of any length are legal.
REQ-023 The bit counter is $clog2(WIDTH) bits wide and increments on each strobe in SHIFT.
REQ-024 On the strobe where the counter equals WIDTH-1: rx_data<=the post-shift shreg value, rx_valid<=1, counter<=0, next state IDLE.
REQ-025 Minimum turnaround is one IDLE cycle between completion and the next load.
REQ-026 rx_valid stays high until a cycle with rx_ack=1; rx_ack while rx_valid=0 has no effect.
REQ-027 If completion and rx_ack coincide, rx_valid remains 1 holding the new word, and no overrun is raised.
REQ-028 shift_en in IDLE has no effect.

Reset
REQ-029 reset=0 asynchronously forces: state IDLE, shreg=0, dir=0, counter=0, rx_data=0, rx_valid=0, overrun=0.
REQ-030 After reset, load_ready=1, busy=0, ser_out=0.
REQ-031 Reset during SHIFT aborts the word; no rx_valid is produced for the aborted word.

Configuration
REQ-032 Macro SPI_SHIFT_OVERRUN_EN controls overrun detection.
REQ-033 With SPI_SHIFT_OVERRUN_EN: if completion occurs while rx_valid=1 and rx_ack=0, overrun<=1 and rx_data keeps the old word; overrun clears on rx_ack.
REQ-034 Without SPI_SHIFT_OVERRUN_EN: the overrun port is absent, and completion always overwrites rx_data.

Verification
REQ-035 WIDTH=8, load 0xA5 with lsb_first=0, ser_in driven with 0x3C MSB-first over 8 strobes -> ser_out sequence 1,0,1,0,0,1,0,1; rx_data=0x3C, rx_valid=1 the cycle after the 8th strobe.
REQ-036 Load 0x01 with lsb_first=1, ser_in driven with 0x80 LSB-first -> ser_out sequence 1,0,0,0,0,0,0,0; rx_data=0x80.
REQ-037 Strobes every 3rd cycle with random gaps -> result identical to REQ-035; busy=1 throughout; load_valid pulses during SHIFT are ignored.
REQ-038 Reset asserted after 4 strobes -> all outputs take reset values immediately; the next full transfer completes correctly.
REQ-039 With SPI_SHIFT_OVERRUN_EN, two words 0x11 then 0x22 without rx_ack -> overrun=1, rx_data=0x11; rx_ack clears rx_valid and overrun.
REQ-040 rx_ack on the completion cycle of a second word -> rx_valid=1, rx_data=second word, overrun=0.
